cnn_bn_relu_256: RTL and testbench

Per-channel affine (folded batch-norm scale and bias) plus ReLU stage placed directly downstream of the 3x3 conv tile. It consumes the tile's channel-summed output stream (`pxl_out`/`valid_out`) and applies `y = relu(sat((x*scale[c]) >>> FRAC_BITS + bias[c]))`. Scales and biases come from a serial parameter stream loaded once after reset. It emits the activated stream with a frame-end marker for the next conv or concat stage.

---
 rtl/cnn_bn_relu_256_pkg.sv | 32 +++
 rtl/cnn_bn_relu_256_if.sv | 27 ++
 rtl/cnn_bn_relu_256_bn_param_ram.sv | 26 ++
 rtl/cnn_bn_relu_256.sv | 156 +++++++++++++++
 tb/tb_cnn_bn_relu_256.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cnn_bn_relu_256_pkg.sv
// Shared types and width helpers for the folded batch-norm + ReLU stage (package param_def_bn_relu).
package param_def_bn_relu;

   localparam int unsigned DEF_DATA_WIDTH      = 16;
   localparam int unsigned DEF_FRAC_BITS       = 8;
   localparam int unsigned DEF_IMAGE_WIDTH     = 256;
   localparam int unsigned DEF_IMAGE_HEIGHT    = 256;
   localparam int unsigned DEF_CHANNEL_NUM_OUT = 256;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } bn_state_e;

   function automatic int unsigned ch_cnt_width(input int unsigned ch_num);
      return (ch_num > 1) ? $clog2(ch_num) : 1;
   endfunction

   function automatic int unsigned param_cnt_width(input int unsigned ch_num);
      return $clog2(2 * ch_num);
   endfunction

   function automatic int unsigned pix_cnt_width(input int unsigned w, input int unsigned h);
      return (w * h > 1) ? $clog2(w * h) : 1;
   endfunction

   // Upper clamp of the ReLU6 activation (6.0 in the fixed-point format).
   function automatic longint relu6_max(input int unsigned frac_bits);
      return longint'(6) << frac_bits;
   endfunction

endpackage

// File: rtl/cnn_bn_relu_256_if.sv
// Parameter, pixel-in and activated-pixel-out signals of the batch-norm + ReLU stage.
interface cnn_bn_relu_256_if
   import param_def_bn_relu::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  stride2;
   logic                  valid_param_in;
   logic [DATA_WIDTH-1:0] param_in;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] pxl_in;
   logic                  param_ready;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  valid_out;
   logic                  last_out;
   logic                  err_drop;

   modport master (
      output stride2, valid_param_in, param_in, valid_in, pxl_in,
      input  param_ready, pxl_out, valid_out, last_out, err_drop
   );

   modport slave (
      input  stride2, valid_param_in, param_in, valid_in, pxl_in,
      output param_ready, pxl_out, valid_out, last_out, err_drop
   );
endinterface

// File: rtl/cnn_bn_relu_256_bn_param_ram.sv
// Simple dual-port synchronous RAM holding one per-channel parameter table.
module bn_param_ram
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [WIDTH-1:0]      wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [WIDTH-1:0]      rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Contents survive reset; tables are simply rewritten on every load.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/cnn_bn_relu_256.sv
// Per-channel affine (folded batch-norm) + ReLU stage with a 3-cycle pipeline.
// Define BN_RELU6_EN to clamp the activation to [0, 6.0] (ReLU6) instead of plain ReLU.
module cnn_bn_relu_256
   import param_def_bn_relu::*;
#(
   parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_BITS       = DEF_FRAC_BITS,
   parameter int unsigned IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
   parameter int unsigned IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
   parameter int unsigned CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT
) (
   input logic clk,
   input logic reset,
   cnn_bn_relu_256_if.slave bus
);
   localparam int unsigned CH_CNT_WIDTH    = ch_cnt_width(CHANNEL_NUM_OUT);
   localparam int unsigned PARAM_CNT_WIDTH = param_cnt_width(CHANNEL_NUM_OUT);
   localparam int unsigned PIX_CNT_WIDTH   = pix_cnt_width(IMAGE_WIDTH, IMAGE_HEIGHT);
   localparam int unsigned PROD_W          = 2 * DATA_WIDTH;
   // Wide enough for shifted product plus bias, so saturation sees the true sum.
   localparam int unsigned SUM_W           = PROD_W - FRAC_BITS + 1;
   localparam int unsigned NPIX_FULL       = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int unsigned NPIX_HALF       = (IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2);
`ifdef BN_RELU6_EN
   localparam longint ACT_MAX = relu6_max(FRAC_BITS);
`else
   localparam longint ACT_MAX = (longint'(1) << (DATA_WIDTH - 1)) - 1;
`endif
   localparam logic signed [SUM_W-1:0] ACT_MAX_S = SUM_W'(ACT_MAX);

   bn_state_e                    state_q;
   logic [PARAM_CNT_WIDTH-1:0]   param_cnt_q;
   logic [CH_CNT_WIDTH-1:0]      ch_q;
   logic [PIX_CNT_WIDTH-1:0]     pix_cnt_q;
   logic                         stride2_q, param_ready_q, err_drop_q;
   logic                         v1_q, last1_q, v2_q, last2_q;
   logic signed [DATA_WIDTH-1:0] x1_q, bias2_q;
   logic signed [PROD_W-1:0]     prod2_q;
   logic [DATA_WIDTH-1:0]        pxl_out_q;
   logic                         valid_out_q, last_out_q;

   logic signed [DATA_WIDTH-1:0] scale_rd, bias_rd;
   logic signed [PROD_W-1:0]     prod_c;
   logic signed [SUM_W-1:0]      shifted_c, sum_c;
   logic [DATA_WIDTH-1:0]        act_c;
   logic                         load_wr_c, wr_bias_c, accept_c, ch_wrap_c, frame_end_c;
   logic [CH_CNT_WIDTH-1:0]      wr_addr_c;
   logic [PIX_CNT_WIDTH-1:0]     npix_last_c;

   assign load_wr_c   = (state_q == ST_LOAD) && bus.valid_param_in;
   assign wr_bias_c   = param_cnt_q >= PARAM_CNT_WIDTH'(CHANNEL_NUM_OUT);
   assign wr_addr_c   = wr_bias_c ? CH_CNT_WIDTH'(param_cnt_q - PARAM_CNT_WIDTH'(CHANNEL_NUM_OUT))
                                  : CH_CNT_WIDTH'(param_cnt_q);
   assign accept_c    = (state_q == ST_RUN) && bus.valid_in;
   assign ch_wrap_c   = ch_q == CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1);
   assign npix_last_c = stride2_q ? PIX_CNT_WIDTH'(NPIX_HALF - 1) : PIX_CNT_WIDTH'(NPIX_FULL - 1);
   assign frame_end_c = ch_wrap_c && (pix_cnt_q == npix_last_c);

   bn_param_ram #(.WIDTH(DATA_WIDTH), .DEPTH(CHANNEL_NUM_OUT), .ADDR_WIDTH(CH_CNT_WIDTH)) u_scale_ram (
      .clk     (clk),
      .we_i    (load_wr_c && !wr_bias_c),
      .waddr_i (wr_addr_c),
      .wdata_i (bus.param_in),
      .re_i    (state_q == ST_RUN),
      .raddr_i (ch_q),
      .rdata_o (scale_rd)
   );

   bn_param_ram #(.WIDTH(DATA_WIDTH), .DEPTH(CHANNEL_NUM_OUT), .ADDR_WIDTH(CH_CNT_WIDTH)) u_bias_ram (
      .clk     (clk),
      .we_i    (load_wr_c && wr_bias_c),
      .waddr_i (wr_addr_c),
      .wdata_i (bus.param_in),
      .re_i    (state_q == ST_RUN),
      .raddr_i (ch_q),
      .rdata_o (bias_rd)
   );

   // S2 multiply and S3 floor-shift, bias add, saturate and clamp.
   assign prod_c    = PROD_W'(x1_q) * PROD_W'(scale_rd);
   assign shifted_c = SUM_W'(prod2_q >>> FRAC_BITS);
   assign sum_c     = shifted_c + SUM_W'(bias2_q);

   always_comb begin
      act_c = '0;
      if (sum_c > ACT_MAX_S)   act_c = DATA_WIDTH'(ACT_MAX_S);
      else if (sum_c > 0)      act_c = DATA_WIDTH'(sum_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_LOAD;
         param_cnt_q   <= '0;
         ch_q          <= '0;
         pix_cnt_q     <= '0;
         stride2_q     <= 1'b0;
         param_ready_q <= 1'b0;
         err_drop_q    <= 1'b0;
         v1_q          <= 1'b0;
         last1_q       <= 1'b0;
         v2_q          <= 1'b0;
         last2_q       <= 1'b0;
         x1_q          <= '0;
         bias2_q       <= '0;
         prod2_q       <= '0;
         pxl_out_q     <= '0;
         valid_out_q   <= 1'b0;
         last_out_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               stride2_q <= bus.stride2;
               if (bus.valid_in) err_drop_q <= 1'b1;
               if (bus.valid_param_in) begin
                  if (param_cnt_q == PARAM_CNT_WIDTH'(2 * CHANNEL_NUM_OUT - 1)) begin
                     state_q       <= ST_RUN;
                     param_ready_q <= 1'b1;
                     param_cnt_q   <= '0;
                  end else begin
                     param_cnt_q <= param_cnt_q + PARAM_CNT_WIDTH'(1);
                  end
               end
            end
            ST_RUN:  ;
            default: state_q <= ST_LOAD;
         endcase

         // Channel/pixel counters advance only on accepted beats.
         if (accept_c) begin
            if (ch_wrap_c) begin
               ch_q      <= '0;
               pix_cnt_q <= frame_end_c ? '0 : pix_cnt_q + PIX_CNT_WIDTH'(1);
            end else begin
               ch_q <= ch_q + CH_CNT_WIDTH'(1);
            end
         end

         v1_q        <= accept_c;
         last1_q     <= accept_c && frame_end_c;
         x1_q        <= bus.pxl_in;
         v2_q        <= v1_q;
         last2_q     <= last1_q;
         prod2_q     <= prod_c;
         bias2_q     <= bias_rd;
         valid_out_q <= v2_q;
         last_out_q  <= last2_q;
         if (v2_q) pxl_out_q <= act_c;
      end
   end

   assign bus.param_ready = param_ready_q;
   assign bus.pxl_out     = pxl_out_q;
   assign bus.valid_out   = valid_out_q;
   assign bus.last_out    = last_out_q;
   assign bus.err_drop    = err_drop_q;
endmodule

// File: tb/tb_cnn_bn_relu_256.sv
// Directed bench for cnn_bn_relu_256 with a 4-channel, 4x4 configuration.
module tb_cnn_bn_relu_256;
   localparam int unsigned DW = 16;
   localparam int unsigned FB = 8;
   localparam int unsigned IW = 4;
   localparam int unsigned IH = 4;
   localparam int unsigned CH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cnn_bn_relu_256_if #(.DATA_WIDTH(DW)) bus ();

   cnn_bn_relu_256 #(
      .DATA_WIDTH(DW), .FRAC_BITS(FB), .IMAGE_WIDTH(IW),
      .IMAGE_HEIGHT(IH), .CHANNEL_NUM_OUT(CH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [16:0] out_q [$];
   logic [15:0] sc [4];
   logic [15:0] bi [4];

   always @(negedge clk) if (bus.valid_out === 1'b1) out_q.push_back({bus.last_out, bus.pxl_out});

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic s2);
      bus.stride2        = s2;
      bus.valid_param_in = 1'b0;
      bus.valid_in       = 1'b0;
      reset              = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic load_params(input logic [15:0] s [4], input logic [15:0] b [4], input bit drop_in);
      for (int i = 0; i < 8; i++) begin
         bus.valid_param_in = 1'b1;
         bus.param_in       = (i < 4) ? s[i] : b[i-4];
         bus.valid_in       = drop_in && (i % 2 == 0);
         bus.pxl_in         = 16'h1234;
         if (i == 7) check_val("pready_before_last", 32'(bus.param_ready), 32'h0);
         tick();
         if (drop_in && i < 7) begin
            bus.valid_param_in = 1'b0;
            bus.valid_in       = 1'b1;
            tick();
         end
      end
      bus.valid_param_in = 1'b0;
      bus.valid_in       = 1'b0;
      check_val("pready_after_load", 32'(bus.param_ready), 32'h1);
   endtask

   task automatic send_check(input string tag, input logic [15:0] x, input logic [15:0] exp);
      bus.valid_in = 1'b1;
      bus.pxl_in   = x;
      tick();
      bus.valid_in = 1'b0;
      tick();
      tick();
      check_val({tag, "_valid"}, 32'(bus.valid_out), 32'h1);
      check_val(tag, 32'(bus.pxl_out), 32'(exp));
   endtask

   task automatic frame_run(input int nbeats, input int last_every);
      out_q.delete();
      for (int i = 0; i < nbeats; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         repeat (gap) tick();
         bus.valid_in = 1'b1;
         bus.pxl_in   = 16'(i * 16);
         tick();
         bus.valid_in = 1'b0;
      end
      repeat (6) tick();
      check_val("frame_beats", 32'(out_q.size()), 32'(nbeats));
      for (int j = 0; j < out_q.size() && j < nbeats; j++) begin
         logic [16:0] e;
         e = out_q[j];
         check_val($sformatf("frame_last_%0d", j), 32'(e[16]), 32'((j % last_every) == last_every - 1));
         check_val($sformatf("frame_pxl_%0d", j), 32'(e[15:0]), 32'(j * 16));
      end
   endtask

   initial begin
      logic [15:0] exp_relu6_a, exp_relu6_b, exp_sat;
`ifdef BN_RELU6_EN
      exp_relu6_a = 16'h0600; exp_relu6_b = 16'h0600; exp_sat = 16'h0600;
`else
      exp_relu6_a = 16'h0880; exp_relu6_b = 16'h0610; exp_sat = 16'h7FFF;
`endif
      bus.stride2 = 1'b0; bus.valid_param_in = 1'b0; bus.param_in = '0;
      bus.valid_in = 1'b0; bus.pxl_in = '0;
      do_reset(1'b0);
      check_val("rst_valid_out", 32'(bus.valid_out), 32'h0);
      check_val("rst_pxl_out", 32'(bus.pxl_out), 32'h0);
      check_val("rst_last_out", 32'(bus.last_out), 32'h0);
      check_val("rst_err_drop", 32'(bus.err_drop), 32'h0);
      check_val("rst_param_ready", 32'(bus.param_ready), 32'h0);

      // Identity scale, bias 0.5: exact 3-cycle latency.
      foreach (sc[i]) begin sc[i] = 16'h0100; bi[i] = 16'h0080; end
      load_params(sc, bi, 1'b0);
      bus.valid_in = 1'b1; bus.pxl_in = 16'h0200;
      tick();
      bus.valid_in = 1'b0;
      check_val("lat_cycle1", 32'(bus.valid_out), 32'h0);
      tick();
      check_val("lat_cycle2", 32'(bus.valid_out), 32'h0);
      tick();
      check_val("lat_cycle3", 32'(bus.valid_out), 32'h1);
      check_val("identity", 32'(bus.pxl_out), 32'h0280);
      check_val("identity_last", 32'(bus.last_out), 32'h0);
      send_check("relu6_clamp", 16'h0800, exp_relu6_a);

      // Distinct per-channel parameters, four back-to-back beats.
      do_reset(1'b0);
      sc[0] = 16'h0100; sc[1] = 16'h0200; sc[2] = 16'h0200; sc[3] = 16'h0080;
      bi[0] = 16'h0000; bi[1] = 16'h0010; bi[2] = 16'h0000; bi[3] = 16'hFF00;
      load_params(sc, bi, 1'b0);
      out_q.delete();
      bus.valid_in = 1'b1;
      bus.pxl_in = 16'hFF00; tick();
      bus.pxl_in = 16'h0300; tick();
      bus.pxl_in = 16'h7F00; tick();
      bus.pxl_in = 16'h0400; tick();
      bus.valid_in = 1'b0;
      repeat (5) tick();
      check_val("mixed_count", 32'(out_q.size()), 32'd4);
      if (out_q.size() == 4) begin
         check_val("neg_clamp", 32'(out_q[0][15:0]), 32'h0000);
         check_val("ch1_scale2_bias", 32'(out_q[1][15:0]), 32'(exp_relu6_b));
         check_val("saturation", 32'(out_q[2][15:0]), 32'(exp_sat));
         check_val("ch3_neg_bias", 32'(out_q[3][15:0]), 32'h0100);
      end

      // Pixels in LOAD are dropped and flagged; load still completes.
      do_reset(1'b0);
      check_val("drop_err_clear", 32'(bus.err_drop), 32'h0);
      out_q.delete();
      foreach (sc[i]) begin sc[i] = 16'h0100; bi[i] = 16'h0080; end
      load_params(sc, bi, 1'b1);
      check_val("drop_no_output", 32'(out_q.size()), 32'h0);
      check_val("drop_err_set", 32'(bus.err_drop), 32'h1);
      send_check("drop_then_run", 16'h0100, 16'h0180);
      check_val("drop_err_sticky", 32'(bus.err_drop), 32'h1);

      // Frame marker, full geometry then stride-2 geometry.
      do_reset(1'b0);
      foreach (sc[i]) begin sc[i] = 16'h0100; bi[i] = 16'h0000; end
      load_params(sc, bi, 1'b0);
      frame_run(64, 64);
      do_reset(1'b1);
      load_params(sc, bi, 1'b0);
      frame_run(32, 16);

      // Reset with two beats in flight.
      out_q.delete();
      bus.valid_in = 1'b1; bus.pxl_in = 16'h0100; tick();
      bus.pxl_in = 16'h0200; tick();
      bus.valid_in = 1'b0;
      reset = 1'b1;
      tick();
      check_val("midrst_valid_out", 32'(bus.valid_out), 32'h0);
      check_val("midrst_param_ready", 32'(bus.param_ready), 32'h0);
      reset = 1'b0;
      repeat (4) tick();
      bus.valid_in = 1'b1; bus.pxl_in = 16'h0300; tick();
      bus.valid_in = 1'b0;
      repeat (4) tick();
      check_val("midrst_flushed", 32'(out_q.size()), 32'h0);
      check_val("midrst_still_load", 32'(bus.param_ready), 32'h0);
      check_val("midrst_err_drop", 32'(bus.err_drop), 32'h1);
      foreach (sc[i]) begin sc[i] = 16'h0100; bi[i] = 16'h0080; end
      load_params(sc, bi, 1'b0);
      send_check("midrst_reload", 16'h0200, 16'h0280);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
